// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, in-order instruction fetch into a small buffer, decode handshake, redirect flush
module fetch_unit #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [31:0]     id_inst
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  logic [XLEN-1:0] pc_q, pc_d, rpc_q, rpc_d, tgt;
  logic [XLEN-1:0] bpc_q [BUF_DEPTH];
  logic [31:0] binst_q [BUF_DEPTH];
  logic [PW-1:0] hd_q, hd_d, tl_q, tl_d;
  logic [CW-1:0] cnt_q, cnt_d, osd_q, osd_d, dsc_q, dsc_d;
  logic [CW:0] occ;
  logic pop, fire, wr, unused_lo;
  assign unused_lo = ^redirect_pc[1:0];
  // Issue/accept/pop decisions; osd counts every in-flight request, dsc the subset still to be dropped
  always_comb begin
    tgt = {redirect_pc[XLEN-1:2], 2'b00};
    id_valid = cnt_q != '0;
    pop = id_valid & id_ready & !redirect_valid;
    occ = {1'b0, cnt_q} + {1'b0, osd_q} - (CW+1)'(id_valid & id_ready);
    imem_req_valid = !rst & !redirect_valid & (occ < (CW+1)'(BUF_DEPTH));
    imem_req_addr = pc_q;
    fire = imem_req_valid & imem_req_ready;
    wr = imem_resp_valid & !redirect_valid & (dsc_q == '0);
    pc_d = redirect_valid ? tgt : fire ? pc_q + XLEN'(4) : pc_q;
    rpc_d = redirect_valid ? tgt : wr ? rpc_q + XLEN'(4) : rpc_q;
    cnt_d = redirect_valid ? '0 : cnt_q + CW'(wr) - CW'(pop);
    osd_d = osd_q + CW'(fire) - CW'(imem_resp_valid);
    dsc_d = redirect_valid ? osd_q - CW'(imem_resp_valid) : dsc_q - CW'(imem_resp_valid & (dsc_q != '0));
    hd_d = redirect_valid ? '0 : hd_q + PW'(pop);
    tl_d = redirect_valid ? '0 : tl_q + PW'(wr);
    id_pc = bpc_q[hd_q];
    id_pc_plus4 = bpc_q[hd_q] + XLEN'(4);
    id_inst = binst_q[hd_q];
  end
  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      rpc_q <= RESET_PC;
      hd_q <= '0;
      tl_q <= '0;
      cnt_q <= '0;
      osd_q <= '0;
      dsc_q <= '0;
    end else begin
      pc_q <= pc_d;
      rpc_q <= rpc_d;
      hd_q <= hd_d;
      tl_q <= tl_d;
      cnt_q <= cnt_d;
      osd_q <= osd_d;
      dsc_q <= dsc_d;
    end
  end
  // Buffer payload written at the tail on a kept response
  always_ff @(posedge clk) begin
    if (wr) begin
      bpc_q[tl_q] <= rpc_q;
      binst_q[tl_q] <= imem_resp_data;
    end
  end
  // Memory protocol checks: no response into a full buffer, no response without a request
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wr && !pop && cnt_q == CW'(BUF_DEPTH)));
      assert (!(imem_resp_valid && osd_q == '0));
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch/redirect/wrap sequence plus a short random run against a PC model
module tb_fetch_unit;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 1, imem_resp_valid = 0, redirect_valid = 0;
  logic id_valid, id_ready = 0;
  logic [31:0] imem_req_addr, imem_resp_data = 0, redirect_pc = 0, id_pc, id_pc_plus4, id_inst;
  typedef struct {logic [31:0] a; int due;} req_t;
  req_t mq[$];
  int cyc = 0, lat = 1, last_due = 0, n = 0, bad = 0;
  logic [31:0] exp_pc = 32'h100;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h100), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_inst(id_inst));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: memory response, decode-stream check, request capture, then advance to the next negedge
  task automatic tick();
    int d;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1;
      imem_resp_data = mem(mq[0].a);
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 0;
      imem_resp_data = 32'hDEAD_BEEF;
    end
    #1;
    if (rst) mq.delete();
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    else if (id_valid && id_ready) begin
      chk("stream_pc", id_pc, exp_pc);
      chk("stream_pc4", id_pc_plus4, exp_pc + 32'd4);
      chk("stream_inst", id_inst, mem(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (imem_req_valid && imem_req_ready) begin
      d = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = d;
      mq.push_back('{imem_req_addr, d});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_id_valid", 32'(id_valid), 0);
    rst = 0; id_ready = 1; #1;
    chk("first_req_valid", 32'(imem_req_valid), 1);
    chk("first_req_addr", imem_req_addr, 32'h100);
    chk("first_id_valid", 32'(id_valid), 0);
    tick();
    chk("b_req_addr", imem_req_addr, 32'h104);
    chk("b_id_valid", 32'(id_valid), 0);
    tick();
    chk("c_id_valid", 32'(id_valid), 1);
    chk("c_id_pc", id_pc, 32'h100);
    chk("c_id_pc4", id_pc_plus4, 32'h104);
    chk("c_id_inst", id_inst, mem(32'h100));
    chk("c_req_addr", imem_req_addr, 32'h108);
    tick();
    repeat (6) begin
      chk("nogap_id_valid", 32'(id_valid), 1);
      tick();
    end
    id_ready = 0; #1;
    chk("bp_req_valid", 32'(imem_req_valid), 0);
    tick();
    repeat (9) begin
      chk("bp_hold_req", 32'(imem_req_valid), 0);
      chk("bp_hold_pc", id_pc, 32'h11C);
      tick();
    end
    id_ready = 1; #1;
    chk("rel_req_valid", 32'(imem_req_valid), 1);
    chk("rel_req_addr", imem_req_addr, 32'h124);
    repeat (4) tick();
    lat = 3;
    repeat (2) tick();
    chk("inflight_id_valid", 32'(id_valid), 0);
    chk("inflight_req_valid", 32'(imem_req_valid), 0);
    redirect_valid = 1; redirect_pc = 32'h2002;
    tick();
    redirect_valid = 0; #1;
    chk("rd1_req_valid", 32'(imem_req_valid), 0);
    chk("rd1_id_valid", 32'(id_valid), 0);
    tick();
    chk("rd2_req_valid", 32'(imem_req_valid), 1);
    chk("rd2_req_addr", imem_req_addr, 32'h2000);
    tick();
    chk("rd3_req_addr", imem_req_addr, 32'h2004);
    chk("rd3_id_valid", 32'(id_valid), 0);
    tick();
    chk("rd4_req_valid", 32'(imem_req_valid), 0);
    tick();
    chk("rd5_id_valid", 32'(id_valid), 0);
    tick();
    chk("rd6_id_valid", 32'(id_valid), 1);
    chk("rd6_id_pc", id_pc, 32'h2000);
    chk("rd6_id_inst", id_inst, mem(32'h2000));
    lat = 1;
    tick();
    chk("sim_id_pc", id_pc, 32'h2004);
    redirect_valid = 1; redirect_pc = 32'h3000; #1;
    chk("sim_req_valid", 32'(imem_req_valid), 0);
    tick();
    redirect_valid = 0; #1;
    chk("sim_empty", 32'(id_valid), 0);
    chk("sim_req_valid2", 32'(imem_req_valid), 1);
    chk("sim_req_addr", imem_req_addr, 32'h3000);
    tick();
    chk("sim_empty2", 32'(id_valid), 0);
    chk("sim_req_addr2", imem_req_addr, 32'h3004);
    tick();
    chk("sim_tgt_valid", 32'(id_valid), 1);
    chk("sim_tgt_pc", id_pc, 32'h3000);
    redirect_valid = 1; redirect_pc = 32'h5000;
    tick();
    redirect_pc = 32'hFFFF_FFFA;
    tick();
    redirect_valid = 0; #1;
    chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
    chk("wrap_id_valid", 32'(id_valid), 0);
    tick();
    chk("wrap_addr1", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr2", imem_req_addr, 32'h0);
    chk("wrap_pc0", id_pc, 32'hFFFF_FFF8);
    tick();
    chk("wrap_pc1", id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", id_pc_plus4, 32'h0);
    tick();
    repeat (300) begin
      imem_req_ready = $urandom_range(3) != 0;
      id_ready = $urandom_range(3) != 0;
      redirect_valid = $urandom_range(15) == 0;
      redirect_pc = $urandom;
      lat = $urandom_range(5, 1);
      tick();
    end
    imem_req_ready = 1; id_ready = 1; redirect_valid = 0; lat = 1;
    repeat (20) tick();
    chk("drain_flowing", 32'(id_valid), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
